gfx_line_pixel_writer: RTL and testbench
========================================

// Module: gfx_line_pixel_writer
// PURPOSE
//  Downstream stage of bresenham_line. Consumes its major/minor/x_major/valid stream and paces it with read_pixel.
//  Buffers points in a small FIFO, maps major/minor back to x/y and clips against a clip rectangle.
//  Emits pixel-write requests (x, y, linear pixel address) to the memory/blend stage over a valid/ack handshake.
// PARAMETERS
//  point_width  16  width of major/minor/x/y/clip coordinates (signed)
//  addr_width   32  width of pixel address output
//  fifo_depth   4   point FIFO entries; must be a power of 2 and >= 4
// PORTS
//  clk_i          in   1            clock
//  rst_i          in   1            asynchronous active-high reset
//  line_busy_i    in   1            busy_o of bresenham_line
//  line_valid_i   in   1            valid_o of bresenham_line: point present this cycle
//  x_major_i      in   1            x_major_o of bresenham_line
//  major_i        in   point_width  major_o of bresenham_line (signed)
//  minor_i        in   point_width  minor_o of bresenham_line (signed)
//  read_pixel_o   out  1            to bresenham_line read_pixel_i: request next point
//  clip_x0_i      in   point_width  clip rect left, inclusive
//  clip_y0_i      in   point_width  clip rect top, inclusive
//  clip_x1_i      in   point_width  clip rect right, exclusive
//  clip_y1_i      in   point_width  clip rect bottom, exclusive
//  base_i         in   addr_width   target buffer base address (in pixels)
//  stride_i       in   point_width  target buffer width in pixels (unsigned)
//  write_o        out  1            pixel write request valid
//  ack_i          in   1            downstream accepts the request
//  x_o, y_o       out  point_width  pixel coordinates of the request
//  addr_o         out  addr_width   base_i + y*stride_i + x, truncated to addr_width
//  busy_o         out  1            line_busy_i | FIFO non-empty | write_o
//  done_o         out  1            one-cycle pulse when busy_o falls 1->0
//  overflow_o     out  1            sticky: a point arrived while FIFO full (dropped)
// BEHAVIOUR
//  Reset (async, any cycle, incl. mid-line): FIFO emptied; read_pixel_o, write_o, done_o, overflow_o,
//   busy_o = 0; x_o, y_o, addr_o = 0. Clip/base/stride are sampled live, not latched.
//  Push: every cycle line_valid_i=1 stores {x,y}: x_major_i ? (major_i, minor_i) : (minor_i, major_i).
//   Full FIFO and no pop that cycle -> point dropped, overflow_o set until reset. Push+pop when full is legal.
//  read_pixel_o = registered-count <= fifo_depth-3 (combinational from count). Slack covers the 1-cycle
//   read->valid latency of the line stage plus its unsolicited first point; overflow_o must never set.
//  Output register: a single stage. Loaded from FIFO head when write_o=0 or (write_o & ack_i).
//   Head is popped regardless; if it fails clip (x<clip_x0 | x>=clip_x1 | y<clip_y0 | y>=clip_y1, signed)
//   it is discarded and write_o goes/stays 0 that cycle. Inside points set write_o=1 next cycle.
//  write_o, x_o, y_o, addr_o are held stable while write_o=1 and ack_i=0. Throughput 1 pixel/cycle with ack_i=1.
//  Latency: line_valid_i at cycle N -> write_o at N+2 (FIFO empty, output free).
//  addr_o computed when the output register loads: y*stride_i as unsigned product of y (non-negative after clip).
//  Order preserved; no point duplicated. done_o pulses the cycle after busy_o falls; not pulsed after reset.
//  Degenerate clip (x1<=x0 or y1<=y0): all points discarded, busy/done still complete normally.
// TESTING
//  Horizontal line (0,0)->(3,0), ack_i=1, clip 0..640x0..480, base 0, stride 640 -> writes x=0..3,y=0,
//   addr 0,1,2,3 in order; done_o one pulse; overflow_o=0.
//  Steep line (2,0)->(3,5) (y-major) -> six writes with y=0..5, x swapped correctly, addr=y*640+x.
//  ack_i held 0 for 20 cycles mid-line -> FIFO fills, read_pixel_o drops, write_o/x_o/y_o/addr_o stable,
//   no overflow; on release all points emitted in order, none lost.
//  Clip rect x 2..4 on line (0,1)->(7,1) -> only x=2,3 written; done_o still pulses once.
//  Line with negative start (-5,-5)->(5,5) -> only on-screen points (0,0)..(5,5) written, ordered.
//  Assert rst_i for one cycle while write_o=1 mid-line -> all outputs 0 immediately (async); after release
//   a new line draws correctly with no stale pixel emitted.

Source files
------------

// File: rtl/gfx_line_pixel_writer.sv
// gfx_line_pixel_writer
// Takes the major/minor point stream of a Bresenham line stage and turns it
// into clipped pixel-write requests. The upstream stage is paced through
// read_pixel_o so that the small point FIFO never overflows. A single output
// register presents x/y/address to the memory stage over a valid/ack handshake.
module gfx_line_pixel_writer #(
    parameter int point_width = 16,
    parameter int addr_width  = 32,
    parameter int fifo_depth  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          line_busy_i,
    input  logic                          line_valid_i,
    input  logic                          x_major_i,
    input  logic signed [point_width-1:0] major_i,
    input  logic signed [point_width-1:0] minor_i,
    output logic                          read_pixel_o,
    input  logic signed [point_width-1:0] clip_x0_i,
    input  logic signed [point_width-1:0] clip_y0_i,
    input  logic signed [point_width-1:0] clip_x1_i,
    input  logic signed [point_width-1:0] clip_y1_i,
    input  logic        [addr_width-1:0]  base_i,
    input  logic        [point_width-1:0] stride_i,
    output logic                          write_o,
    input  logic                          ack_i,
    output logic        [point_width-1:0] x_o,
    output logic        [point_width-1:0] y_o,
    output logic        [addr_width-1:0]  addr_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
);

    localparam int PTR_W  = $clog2(fifo_depth);
    localparam int CNT_W  = PTR_W + 1;
    // Wide enough for the full y*stride product and for the address itself
    localparam int WIDE_W = (addr_width > 2 * point_width) ? addr_width : 2 * point_width;

    // Point storage; contents need no reset, only the pointers/count do
    logic signed [point_width-1:0] fifo_x_q [fifo_depth];
    logic signed [point_width-1:0] fifo_y_q [fifo_depth];

    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          overflow_q, overflow_d;
    logic                          write_q, write_d;
    logic signed [point_width-1:0] x_q, x_d;
    logic signed [point_width-1:0] y_q, y_d;
    logic [addr_width-1:0]         addr_q, addr_d;
    logic                          busy_prev_q, busy_prev_d;
    logic                          done_q, done_d;

    logic                          fifo_empty;
    logic                          fifo_full;
    logic                          load_en;
    logic                          pop;
    logic                          push;
    logic                          drop;
    logic                          busy_now;
    logic signed [point_width-1:0] push_x;
    logic signed [point_width-1:0] push_y;
    logic signed [point_width-1:0] head_x;
    logic signed [point_width-1:0] head_y;
    logic                          head_in_clip;
    logic [WIDE_W-1:0]             x_wide;
    logic [WIDE_W-1:0]             y_wide;
    logic [WIDE_W-1:0]             stride_wide;
    logic [WIDE_W-1:0]             base_wide;
    logic [WIDE_W-1:0]             addr_wide;

    // FIFO control, clip test and address arithmetic for the head entry
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(fifo_depth));
        // The output register can take a new point when idle or being acked
        load_en    = ~write_q | ack_i;
        pop        = load_en & ~fifo_empty;
        // A full FIFO still accepts a point if the head leaves in the same cycle
        push       = line_valid_i & (~fifo_full | pop);
        drop       = line_valid_i & fifo_full & ~pop;

        // Undo the major/minor swap of the line stage
        push_x     = x_major_i ? major_i : minor_i;
        push_y     = x_major_i ? minor_i : major_i;

        head_x     = fifo_x_q[rd_ptr_q];
        head_y     = fifo_y_q[rd_ptr_q];

        head_in_clip = (head_x >= clip_x0_i) && (head_x < clip_x1_i) &&
                       (head_y >= clip_y0_i) && (head_y < clip_y1_i);

        // y is non-negative for any point that survives clipping, so it is
        // multiplied as unsigned; x keeps its sign so negative clip origins work
        x_wide      = {{(WIDE_W - point_width){head_x[point_width-1]}}, head_x};
        y_wide      = {{(WIDE_W - point_width){1'b0}}, head_y};
        stride_wide = {{(WIDE_W - point_width){1'b0}}, stride_i};
        base_wide   = WIDE_W'(base_i);
        addr_wide   = base_wide + y_wide * stride_wide + x_wide;

        busy_now    = line_busy_i | ~fifo_empty | write_q;
    end

    // Next-state logic for pointers, count, output register and status flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d  = overflow_q | drop;
        write_d     = write_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        busy_prev_d = busy_now;
        done_d      = busy_prev_q & ~busy_now;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (load_en) begin
            if (pop) begin
                // Clipped points are consumed but never presented downstream
                write_d = head_in_clip;
                x_d     = head_x;
                y_d     = head_y;
                addr_d  = addr_wide[addr_width-1:0];
            end else begin
                write_d = 1'b0;
            end
        end
    end

    // Point storage write port
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_x_q[wr_ptr_q] <= push_x;
            fifo_y_q[wr_ptr_q] <= push_y;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            write_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            busy_prev_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            write_q     <= write_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            busy_prev_q <= busy_prev_d;
            done_q      <= done_d;
        end
    end

    // Outputs; the request/busy gating keeps everything quiet while reset is held
    always_comb begin
        // Two free slots cover the one-cycle read->valid latency plus the
        // unsolicited first point of a new line
        read_pixel_o = ~rst_i & (count_q <= CNT_W'(fifo_depth - 3));
        busy_o       = ~rst_i & busy_now;
        write_o      = write_q;
        x_o          = x_q;
        y_o          = y_q;
        addr_o       = addr_q;
        done_o       = done_q;
        overflow_o   = overflow_q;
    end

endmodule

// File: tb/tb_gfx_line_pixel_writer.sv
// Testbench for gfx_line_pixel_writer: emulates the upstream line stage,
// predicts the clipped pixel writes from the geometry and compares.
module tb_gfx_line_pixel_writer;

    localparam int PW = 16;
    localparam int AW = 32;
    localparam int DEPTH = 4;
    localparam int CYC_BUDGET = 3000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 line_busy = 1'b0;
    logic                 line_valid = 1'b0;
    logic                 x_major = 1'b0;
    logic signed [PW-1:0] major = '0;
    logic signed [PW-1:0] minor = '0;
    logic                 read_pixel_o;
    logic signed [PW-1:0] clip_x0 = 0, clip_y0 = 0, clip_x1 = 640, clip_y1 = 480;
    logic [AW-1:0]        base_r = '0;
    logic [PW-1:0]        stride_r = 16'd640;
    logic                 write_o;
    logic                 ack = 1'b1;
    logic [PW-1:0]        x_o, y_o;
    logic [AW-1:0]        addr_o;
    logic                 busy_o, done_o, overflow_o;

    always #5 clk = ~clk;

    gfx_line_pixel_writer #(
        .point_width(PW), .addr_width(AW), .fifo_depth(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .line_busy_i(line_busy), .line_valid_i(line_valid),
        .x_major_i(x_major), .major_i(major), .minor_i(minor), .read_pixel_o(read_pixel_o),
        .clip_x0_i(clip_x0), .clip_y0_i(clip_y0), .clip_x1_i(clip_x1), .clip_y1_i(clip_y1),
        .base_i(base_r), .stride_i(stride_r), .write_o(write_o), .ack_i(ack),
        .x_o(x_o), .y_o(y_o), .addr_o(addr_o), .busy_o(busy_o), .done_o(done_o),
        .overflow_o(overflow_o)
    );

    typedef struct { int x; int y; } pt_t;
    typedef struct { int x; int y; logic [AW-1:0] addr; } wr_t;

    pt_t pts[$];
    wr_t obs[$];
    wr_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int done_cnt, stable_err, timed_out;
    bit ovf_seen, rp_low_seen;
    int ack_mode, ack_pct, stall_start, stall_len;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference rasteriser: the points a Bresenham line stage delivers, in order
    task automatic gen_line(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        dx = iabs(x1 - x0);
        dy = -iabs(y1 - y0);
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        pts.delete();
        while (1) begin
            pts.push_back('{x, y});
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Expected writes: points inside the clip rectangle, addr = base + y*stride + x
    task automatic build_expected();
        wr_t e;
        exp_q.delete();
        foreach (pts[i]) begin
            if (pts[i].x >= int'(clip_x0) && pts[i].x < int'(clip_x1) &&
                pts[i].y >= int'(clip_y0) && pts[i].y < int'(clip_y1)) begin
                e.x = pts[i].x;
                e.y = pts[i].y;
                e.addr = AW'(longint'(base_r) + longint'(pts[i].y) * longint'(stride_r) + longint'(pts[i].x));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        line_valid = 1'b0;
        line_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one line as the upstream stage would and records what the DUT emits
    task automatic run_line(input int x0, input int y0, input int x1, input int y1);
        int n, idx, cyc, post, px, py;
        bit rp_prev, first, xm, prev_stall, drove;
        logic [AW-1:0] pa;
        wr_t w;
        gen_line(x0, y0, x1, y1);
        build_expected();
        obs.delete();
        done_cnt = 0; stable_err = 0; timed_out = 0; ovf_seen = 0; rp_low_seen = 0;
        n = pts.size(); idx = 0; cyc = 0; post = 0;
        rp_prev = 0; first = 1; prev_stall = 0; px = 0; py = 0; pa = '0;
        xm = (iabs(x1 - x0) >= iabs(y1 - y0));
        while (1) begin
            @(posedge clk); #1;
            drove = (idx < n) && (first || rp_prev);
            line_valid = drove;
            if (drove) begin
                x_major = xm;
                major = xm ? PW'(pts[idx].x) : PW'(pts[idx].y);
                minor = xm ? PW'(pts[idx].y) : PW'(pts[idx].x);
                idx++;
                first = 0;
            end
            line_busy = (idx < n) || drove;
            case (ack_mode)
                0: ack = 1'b1;
                1: ack = ($urandom_range(0, 99) < ack_pct);
                default: ack = !(cyc >= stall_start && cyc < stall_start + stall_len);
            endcase
            @(negedge clk);
            rp_prev = read_pixel_o;
            if (read_pixel_o !== 1'b1) rp_low_seen = 1;
            if (overflow_o !== 1'b0) ovf_seen = 1;
            if (done_o === 1'b1) done_cnt++;
            if (prev_stall && (write_o !== 1'b1 || int'($signed(x_o)) != px ||
                               int'($signed(y_o)) != py || addr_o !== pa)) stable_err++;
            if (write_o === 1'b1 && ack) begin
                w.x = int'($signed(x_o)); w.y = int'($signed(y_o)); w.addr = addr_o;
                obs.push_back(w);
            end
            prev_stall = (write_o === 1'b1) && !ack;
            px = int'($signed(x_o)); py = int'($signed(y_o)); pa = addr_o;
            if (idx >= n && !drove && busy_o === 1'b0) post++;
            cyc++;
            if (post >= 3) break;
            if (cyc >= CYC_BUDGET) begin timed_out = 1; break; end
        end
        line_valid = 1'b0;
        line_busy = 1'b0;
        ack = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({read_pixel_o, write_o, done_o, overflow_o, busy_o, x_o, y_o, addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rp=%b wr=%b done=%b ovf=%b busy=%b x=%0d y=%0d addr=%0d exp all 0",
                     read_pixel_o, write_o, done_o, overflow_o, busy_o, x_o, y_o, addr_o);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (read_pixel_o !== 1'b1 || busy_o !== 1'b0 || write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rp=%b busy=%b wr=%b exp rp=1 busy=0 wr=0", read_pixel_o, busy_o, write_o);
        end
        $display("test_reset: done");
    endtask

    task automatic test_horizontal();
        clip_x0 = 0; clip_y0 = 0; clip_x1 = 640; clip_y1 = 480; base_r = 0; stride_r = 640;
        ack_mode = 0;
        run_line(0, 0, 3, 0);
        checks++;
        if (timed_out != 0 || obs.size() != 4) begin
            errors++;
            $display("FAIL horiz_count got %0d writes timeout=%0d exp 4", obs.size(), timed_out);
        end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            checks++;
            if (obs[i].x != i || obs[i].y != 0 || obs[i].addr !== AW'(i)) begin
                errors++;
                $display("FAIL horiz_write[%0d] got x=%0d y=%0d addr=%0d exp x=%0d y=0 addr=%0d",
                         i, obs[i].x, obs[i].y, obs[i].addr, i, i);
            end
        end
        checks++;
        if (done_cnt != 1 || ovf_seen) begin
            errors++;
            $display("FAIL horiz_done_ovf got done=%0d ovf=%0d exp done=1 ovf=0", done_cnt, ovf_seen);
        end
        $display("test_horizontal: %0d writes, done pulses %0d", obs.size(), done_cnt);
    endtask

    task automatic test_steep();
        ack_mode = 0;
        run_line(2, 0, 3, 5);
        checks++;
        if (timed_out != 0 || obs.size() != 6) begin
            errors++;
            $display("FAIL steep_count got %0d writes timeout=%0d exp 6", obs.size(), timed_out);
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i].y != i || obs[i].x < 2 || obs[i].x > 3 || obs[i].x != exp_q[i].x ||
                obs[i].addr !== AW'(i * 640 + exp_q[i].x)) begin
                errors++;
                $display("FAIL steep_write[%0d] got x=%0d y=%0d addr=%0d exp x=%0d y=%0d addr=%0d",
                         i, obs[i].x, obs[i].y, obs[i].addr, exp_q[i].x, i, i * 640 + exp_q[i].x);
            end
        end
        checks++;
        if (done_cnt != 1 || ovf_seen) begin
            errors++;
            $display("FAIL steep_done_ovf got done=%0d ovf=%0d exp done=1 ovf=0", done_cnt, ovf_seen);
        end
        $display("test_steep: %0d writes", obs.size());
    endtask

    task automatic test_stall();
        ack_mode = 2; stall_start = 6; stall_len = 20;
        run_line(0, 0, 30, 0);
        checks++;
        if (timed_out != 0 || obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got %0d writes timeout=%0d exp %0d", obs.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i].x != exp_q[i].x || obs[i].y != exp_q[i].y || obs[i].addr !== exp_q[i].addr) begin
                errors++;
                $display("FAIL stall_write[%0d] got x=%0d y=%0d addr=%0d exp x=%0d y=%0d addr=%0d",
                         i, obs[i].x, obs[i].y, obs[i].addr, exp_q[i].x, exp_q[i].y, exp_q[i].addr);
            end
        end
        checks++;
        if (stable_err != 0 || !rp_low_seen || ovf_seen || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_flags got unstable=%0d rp_dropped=%0d ovf=%0d done=%0d exp 0 1 0 1",
                     stable_err, rp_low_seen, ovf_seen, done_cnt);
        end
        $display("test_stall: %0d writes, stall violations %0d", obs.size(), stable_err);
    endtask

    task automatic test_clip_x();
        clip_x0 = 2; clip_x1 = 4;
        ack_mode = 0;
        run_line(0, 1, 7, 1);
        checks++;
        if (timed_out != 0 || obs.size() != 2) begin
            errors++;
            $display("FAIL clipx_count got %0d writes timeout=%0d exp 2", obs.size(), timed_out);
        end
        for (int i = 0; i < obs.size() && i < 2; i++) begin
            checks++;
            if (obs[i].x != 2 + i || obs[i].y != 1 || obs[i].addr !== AW'(640 + 2 + i)) begin
                errors++;
                $display("FAIL clipx_write[%0d] got x=%0d y=%0d addr=%0d exp x=%0d y=1 addr=%0d",
                         i, obs[i].x, obs[i].y, obs[i].addr, 2 + i, 642 + i);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL clipx_done got %0d pulses exp 1", done_cnt);
        end
        clip_x0 = 0; clip_x1 = 640;
        $display("test_clip_x: %0d writes", obs.size());
    endtask

    task automatic test_negative_start();
        ack_mode = 1; ack_pct = 70;
        run_line(-5, -5, 5, 5);
        checks++;
        if (timed_out != 0 || obs.size() != 6) begin
            errors++;
            $display("FAIL negstart_count got %0d writes timeout=%0d exp 6", obs.size(), timed_out);
        end
        for (int i = 0; i < obs.size() && i < 6; i++) begin
            checks++;
            if (obs[i].x != i || obs[i].y != i || obs[i].addr !== AW'(i * 641)) begin
                errors++;
                $display("FAIL negstart_write[%0d] got x=%0d y=%0d addr=%0d exp x=%0d y=%0d addr=%0d",
                         i, obs[i].x, obs[i].y, obs[i].addr, i, i, i * 641);
            end
        end
        $display("test_negative_start: %0d writes", obs.size());
    endtask

    task automatic test_degenerate_clip();
        clip_x0 = 5; clip_x1 = 5;
        ack_mode = 0;
        run_line(0, 3, 9, 3);
        checks++;
        if (timed_out != 0 || obs.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL degen got writes=%0d done=%0d timeout=%0d exp 0 1 0", obs.size(), done_cnt, timed_out);
        end
        clip_x0 = 0; clip_x1 = 640;
        $display("test_degenerate_clip: %0d writes, done pulses %0d", obs.size(), done_cnt);
    endtask

    // Ignores read_pixel_o on purpose to force a drop with the output stalled
    task automatic test_overflow();
        int i;
        wr_t w;
        ack = 1'b0;
        obs.delete();
        for (i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            line_busy = 1'b1; line_valid = 1'b1; x_major = 1'b1;
            major = PW'(10 + i); minor = PW'(3);
        end
        @(posedge clk); #1;
        line_valid = 1'b0; line_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow_o !== 1'b1 || write_o !== 1'b1 || int'($signed(x_o)) != 10) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b wr=%b x=%0d exp ovf=1 wr=1 x=10", overflow_o, write_o, $signed(x_o));
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        ack = 1'b1;
        for (i = 0; i < 12; i++) begin
            @(negedge clk);
            if (write_o === 1'b1 && ack) begin
                w.x = int'($signed(x_o)); w.y = int'($signed(y_o)); w.addr = addr_o;
                obs.push_back(w);
            end
        end
        checks++;
        if (obs.size() != 5) begin
            errors++;
            $display("FAIL ovf_count got %0d writes exp 5", obs.size());
        end
        for (i = 0; i < obs.size() && i < 5; i++) begin
            checks++;
            if (obs[i].x != 10 + i || obs[i].y != 3 || obs[i].addr !== AW'(1920 + 10 + i)) begin
                errors++;
                $display("FAIL ovf_write[%0d] got x=%0d y=%0d addr=%0d exp x=%0d y=3 addr=%0d",
                         i, obs[i].x, obs[i].y, obs[i].addr, 10 + i, 1930 + i);
            end
        end
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b exp 1", overflow_o);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared got %b exp 0", overflow_o);
        end
        $display("test_overflow: %0d writes after release", obs.size());
    endtask

    task automatic test_midline_reset();
        int waited;
        ack = 1'b0;
        @(posedge clk); #1;
        line_busy = 1'b1; line_valid = 1'b1; x_major = 1'b1; major = 16'sd7; minor = 16'sd9;
        @(posedge clk); #1;
        line_valid = 1'b1; major = 16'sd8;
        @(posedge clk); #1;
        line_valid = 1'b0;
        waited = 0;
        while (write_o !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (write_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pending got wr=%b exp 1", write_o);
        end
        @(posedge clk); #2;
        line_busy = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({read_pixel_o, write_o, done_o, overflow_o, busy_o, x_o, y_o, addr_o} !== '0) begin
            errors++;
            $display("FAIL midrst_async got rp=%b wr=%b done=%b ovf=%b busy=%b x=%0d y=%0d addr=%0d exp all 0",
                     read_pixel_o, write_o, done_o, overflow_o, busy_o, x_o, y_o, addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (write_o !== 1'b0 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale[%0d] got wr=%b done=%b exp 0 0", i, write_o, done_o);
            end
        end
        ack_mode = 0;
        run_line(1, 1, 4, 1);
        checks++;
        if (timed_out != 0 || obs.size() != 4) begin
            errors++;
            $display("FAIL midrst_count got %0d writes timeout=%0d exp 4", obs.size(), timed_out);
        end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            checks++;
            if (obs[i].x != 1 + i || obs[i].y != 1 || obs[i].addr !== AW'(641 + i)) begin
                errors++;
                $display("FAIL midrst_write[%0d] got x=%0d y=%0d addr=%0d exp x=%0d y=1 addr=%0d",
                         i, obs[i].x, obs[i].y, obs[i].addr, 1 + i, 641 + i);
            end
        end
        $display("test_midline_reset: %0d writes after reset", obs.size());
    endtask

    task automatic test_random();
        int x0, y0, x1, y1;
        for (int t = 0; t < 8; t++) begin
            clip_x0 = PW'($urandom_range(0, 12));
            clip_y0 = PW'($urandom_range(0, 12));
            clip_x1 = PW'($urandom_range(0, 35));
            clip_y1 = PW'($urandom_range(0, 35));
            base_r = AW'($urandom);
            stride_r = PW'($urandom_range(1, 2000));
            x0 = int'($urandom_range(0, 60)) - 20;
            y0 = int'($urandom_range(0, 60)) - 20;
            x1 = int'($urandom_range(0, 60)) - 20;
            y1 = int'($urandom_range(0, 60)) - 20;
            ack_mode = 1;
            ack_pct = int'($urandom_range(30, 100));
            run_line(x0, y0, x1, y1);
            checks++;
            if (timed_out != 0 || obs.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d writes timeout=%0d exp %0d", t, obs.size(), timed_out, exp_q.size());
            end
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs[i].x != exp_q[i].x || obs[i].y != exp_q[i].y || obs[i].addr !== exp_q[i].addr) begin
                    errors++;
                    $display("FAIL rand%0d_write[%0d] got x=%0d y=%0d addr=%0h exp x=%0d y=%0d addr=%0h",
                             t, i, obs[i].x, obs[i].y, obs[i].addr, exp_q[i].x, exp_q[i].y, exp_q[i].addr);
                end
            end
            checks++;
            if (done_cnt != 1 || ovf_seen || stable_err != 0) begin
                errors++;
                $display("FAIL rand%0d_flags got done=%0d ovf=%0d unstable=%0d exp 1 0 0", t, done_cnt, ovf_seen, stable_err);
            end
            $display("test_random: line (%0d,%0d)->(%0d,%0d) %0d writes", x0, y0, x1, y1, obs.size());
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_stall();
        test_clip_x();
        test_negative_start();
        test_degenerate_clip();
        test_overflow();
        test_midline_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
